// File: rtl/regfile_sb.sv
// regfile_sb: register file with two combinational read ports and one
// byte-masked write port. It also keeps a per-register busy scoreboard and
// a sticky out-of-range error flag.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle write
// to the read ports.
module regfile_sb #(
   parameter int NUM_REGS = 12,
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W/8-1:0]   wr_be,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  rsv_en,
   input  logic [ADDR_W-1:0]     rsv_addr,
   input  logic [ADDR_W-1:0]     rd_addr_a,
   input  logic [ADDR_W-1:0]     rd_addr_b,
   output logic [DATA_W-1:0]     rd_data_a,
   output logic [DATA_W-1:0]     rd_data_b,
   output logic                  rd_busy_a,
   output logic                  rd_busy_b,
   input  logic                  err_clr,
   output logic                  err
);

   localparam int NB = DATA_W / 8;

   logic [DATA_W-1:0]   mem_q [NUM_REGS];
   logic [DATA_W-1:0]   mem_d [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic                err_q, err_d;
   logic                wr_ok, rsv_ok, any_err;
   logic [DATA_W-1:0]   data_a, data_b;
   logic                busy_a, busy_b;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return ({{(32-ADDR_W){1'b0}}, a} < NUM_REGS);
   endfunction

   function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [NB-1:0]     be);
      logic [DATA_W-1:0] res;
      res = old_v;
      for (int i = 0; i < NB; i++) begin
         if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
      end
      return res;
   endfunction

   // Qualify write/reserve strobes and detect any out-of-range access this cycle.
   always_comb begin
      wr_ok   = wr_en && in_range(wr_addr) && !is_zero_reg(wr_addr);
      rsv_ok  = rsv_en && in_range(rsv_addr) && !is_zero_reg(rsv_addr);
      any_err = (wr_en && !in_range(wr_addr)) || (rsv_en && !in_range(rsv_addr)) ||
                !in_range(rd_addr_a) || !in_range(rd_addr_b);
   end

   // Next state: a write clears busy, a reservation then sets it (new producer wins).
   always_comb begin
      mem_d  = mem_q;
      busy_d = busy_q;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (wr_ok && wr_addr == ADDR_W'(r)) begin
            mem_d[r]  = byte_merge(mem_q[r], wr_data, wr_be);
            busy_d[r] = 1'b0;
         end
         if (rsv_ok && rsv_addr == ADDR_W'(r)) busy_d[r] = 1'b1;
      end
      // A new error outranks a same-cycle clear.
      err_d = any_err | (err_q & ~err_clr);
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
         busy_q <= '0;
         err_q  <= 1'b0;
      end else begin
         mem_q  <= mem_d;
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   // Combinational read ports; unmatched (out-of-range) addresses read as zero.
   always_comb begin
      data_a = '0;
      data_b = '0;
      busy_a = 1'b0;
      busy_b = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (rd_addr_a == ADDR_W'(r)) begin
            data_a = mem_q[r];
            busy_a = busy_q[r];
         end
         if (rd_addr_b == ADDR_W'(r)) begin
            data_b = mem_q[r];
            busy_b = busy_q[r];
         end
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && wr_addr == rd_addr_a) begin
         data_a = byte_merge(data_a, wr_data, wr_be);
         busy_a = rsv_ok && (rsv_addr == rd_addr_a);
      end
      if (wr_ok && wr_addr == rd_addr_b) begin
         data_b = byte_merge(data_b, wr_data, wr_be);
         busy_b = rsv_ok && (rsv_addr == rd_addr_b);
      end
`else
`endif
      // Bypass data must not leak out while reset is held.
      if (rst) begin
         data_a = '0;
         data_b = '0;
         busy_a = 1'b0;
         busy_b = 1'b0;
      end
   end

   assign rd_data_a = data_a;
   assign rd_data_b = data_b;
   assign rd_busy_a = busy_a;
   assign rd_busy_b = busy_b;
   assign err       = err_q;

endmodule
